// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU.
// Single-cycle ops: AND, OR, ADD, SUB, SLT, SLTU.
// Iterative ops: MUL (full 2*WIDTH product), DIVU and REMU (restoring divide).
// The FSM state is visible on dbg_state so that checkers can bind to it.
//
// Handshake: a request is taken on a rising edge where i_valid && o_ready.
// Operands and Sel are captured on that edge. A request offered while o_ready
// is low is not taken, and the requester must keep it asserted. Each result
// produces exactly one o_valid cycle. There is no output backpressure.
// r_out, r_hi and Zflag keep their values until the next result is written.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic [3:0]       Sel,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] r_hi,
    output logic             Zflag,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [3:0]         op_q;
    // acc_hi: running product high half (MUL) or partial remainder (DIV).
    // acc_lo: multiplier being shifted out (MUL) or dividend/quotient (DIV).
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    // opb: multiplicand (MUL) or divisor (DIV).
    logic [WIDTH-1:0]   opb;

    logic               accept;
    logic               is_iter;
    logic [WIDTH-1:0]   alu_res;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_trial;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   fin_out;
    logic [WIDTH-1:0]   fin_hi;

    assign dbg_state = state;
    assign accept    = i_valid && o_ready;
    assign is_iter   = (Sel == OP_MUL) || (Sel == OP_DIVU) || (Sel == OP_REMU);

    // Single-cycle result, computed straight from the live request inputs.
    always_comb begin
        alu_res = '0;
        case (Sel)
            OP_AND:  alu_res = i_op1 & i_op2;
            OP_OR:   alu_res = i_op1 | i_op2;
            OP_ADD:  alu_res = i_op1 + i_op2;
            OP_SUB:  alu_res = i_op1 - i_op2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_op1 < i_op2)};
            default: alu_res = '0;
        endcase
    end

    // One iteration step: shift-add for MUL, restoring shift-subtract for DIV.
    // A zero divisor always "fits", which naturally yields an all-ones
    // quotient and leaves the dividend as the remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_trial = div_shift[WIDTH-1:0] - opb;
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_trial : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end
    end

    // Selects what the final iteration writes to the result registers.
    always_comb begin
        fin_out = '0;
        fin_hi  = '0;
        case (op_q)
            OP_MUL: begin
                fin_out = step_lo;
                fin_hi  = step_hi;
            end
            OP_DIVU: fin_out = step_lo;
            OP_REMU: fin_out = step_hi;
            default: fin_out = '0;
        endcase
    end

    // Control FSM plus iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            op_q    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb     <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            r_out   <= '0;
            r_hi    <= '0;
            Zflag   <= 1'b1;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    if (accept) begin
                        if (is_iter) begin
                            op_q    <= Sel;
                            counter <= CNT_W'(WIDTH);
                            acc_hi  <= '0;
                            if (Sel == OP_MUL) begin
                                acc_lo <= i_op2;
                                opb    <= i_op1;
                            end else begin
                                acc_lo <= i_op1;
                                opb    <= i_op2;
                            end
                            o_ready <= 1'b0;
                            state   <= CALC;
                        end else begin
                            r_out   <= alu_res;
                            r_hi    <= '0;
                            Zflag   <= (alu_res == '0);
                            o_valid <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc_hi  <= step_hi;
                    acc_lo  <= step_lo;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        r_out   <= fin_out;
                        r_hi    <= fin_hi;
                        Zflag   <= (fin_out == '0);
                        o_valid <= 1'b1;
                        o_ready <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic [W-1:0] i_op1;
  logic [W-1:0] i_op2;
  logic [3:0]   Sel;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] r_out;
  logic [W-1:0] r_hi;
  logic         Zflag;
  logic [1:0]   dbg_state;

  int checks;
  int failures;
  int cyc;
  int pulse_cnt;
  int prev_pulse_cyc;
  int last_pulse_cyc;

  // {r_hi, r_out, Zflag}
  logic [2*W:0] exp_q[$];
  logic [2*W:0] obs_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_op1(i_op1), .i_op2(i_op2),
    .Sel(Sel), .o_ready(o_ready), .o_valid(o_valid), .r_out(r_out),
    .r_hi(r_hi), .Zflag(Zflag), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // result monitor: collect every o_valid pulse
  always @(negedge clk) begin
    if (o_valid) begin
      obs_q.push_back({r_hi, r_out, Zflag});
      pulse_cnt++;
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
    end
  end

  // reference model
  function automatic logic [2*W:0] model(input logic [3:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0] o;
    logic [W-1:0] h;
    o = '0;
    h = '0;
    case (s)
      4'b0000: o = a & b;
      4'b0001: o = a | b;
      4'b0010: o = a + b;
      4'b0110: o = a - b;
      4'b0111: o = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: o = (a < b) ? 1 : 0;
      4'b0011: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        o = p[W-1:0];
        h = p[2*W-1:W];
      end
      4'b0100: o = (b == 0) ? '1 : a / b;
      4'b0101: o = (b == 0) ? a : a % b;
      default: o = '0;
    endcase
    return {h, o, (o == '0)};
  endfunction

  // driver: wait for ready, present request for one accept edge
  task automatic send(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit push);
    int n;
    n = 0;
    while (!o_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=o_ready=0 exp=o_ready=1");
    end
    Sel = s;
    i_op1 = a;
    i_op2 = b;
    i_valid = 1'b1;
    if (push) exp_q.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset;
    int pc;
    rst = 1'b1;
    i_valid = 1'b1;
    Sel = 4'b0010;
    i_op1 = 32'd3;
    i_op2 = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    i_valid = 1'b0;
    pc = pulse_cnt;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (r_out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", r_out); end
    checks++; if (r_hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", r_hi); end
    checks++; if (Zflag !== 1'b1) begin failures++; $display("FAIL reset_z got=%b exp=1", Zflag); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    repeat (3) @(negedge clk);
    checks++; if (pulse_cnt !== pc) begin failures++; $display("FAIL reset_ivalid_ignored got=%0d exp=%0d", pulse_cnt, pc); end
    obs_q.delete();
  endtask

  task automatic test_single_cycle;
    logic [3:0]   s_tab[12] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1000,
                                4'b1111, 4'b1001, 4'b0111, 4'b0010, 4'b0110, 4'b1100};
    logic [W-1:0] a_tab[12] = '{32'hFFFFFFFF, 32'd5, 32'hF0F0_1234, 32'hF0F0_0000, 32'h7FFFFFFF,
                                32'h7FFFFFFF, 32'hDEAD_BEEF, 32'h1234, 32'h8000_0000,
                                32'h1234_5678, 32'd9, 32'd1};
    logic [W-1:0] b_tab[12] = '{32'd1, 32'd7, 32'h0F0F_FFFF, 32'h0000_0F0F, 32'h8000_0000,
                                32'h8000_0000, 32'h1, 32'h5678, 32'h7FFFFFFF,
                                32'h1111_1111, 32'd9, 32'd1};
    logic [2*W:0] e;
    logic [2*W:0] o;
    int n;
    for (int i = 0; i < 12; i++) send(s_tab[i], a_tab[i], b_tab[i], 1'b1);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL single_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL single_result got=%h exp=%h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL single_extra got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_latency;
    int lat;
    int low;
    logic [2*W:0] e;
    send(4'b0010, 32'hFFFFFFFF, 32'd1, 1'b1);
    lat = 0; low = 0;
    do begin @(negedge clk); lat++; if (!o_ready) low++; end while (!o_valid && lat < 200);
    checks++; if (lat != 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    send(4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    lat = 0; low = 0;
    do begin @(negedge clk); lat++; if (!o_ready) low++; end while (!o_valid && lat < 200);
    checks++; if (lat != W + 1) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", lat, W + 1); end
    checks++; if (low != W) begin failures++; $display("FAIL mul_ready_low got=%0d exp=%0d", low, W); end
    checks++; if (r_hi !== 32'hFFFFFFFE || r_out !== 32'h1) begin
      failures++; $display("FAIL mul_ff got=%h_%h exp=fffffffe_00000001", r_hi, r_out); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL lat_missing got=none exp=%h", e); end
      else if (obs_q[0] !== e) begin failures++; $display("FAIL lat_result got=%h exp=%h", obs_q.pop_front(), e); end
      else void'(obs_q.pop_front());
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [2*W:0] e;
    logic [2*W:0] o;
    int n;
    send(4'b0111, 32'hFFFFFFFF, 32'd1, 1'b1);
    send(4'b1000, 32'hFFFFFFFF, 32'd1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (last_pulse_cyc - prev_pulse_cyc != 1) begin
      failures++; $display("FAIL b2b_single_gap got=%0d exp=1", last_pulse_cyc - prev_pulse_cyc); end
    // DONE cycle accepts the next request
    send(4'b0011, 32'd3, 32'd4, 1'b1);
    send(4'b0010, 32'd10, 32'd20, 1'b1);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (last_pulse_cyc - prev_pulse_cyc != 1) begin
      failures++; $display("FAIL b2b_done_gap got=%0d exp=1", last_pulse_cyc - prev_pulse_cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL b2b_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL b2b_result got=%h exp=%h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_mul_div;
    logic [3:0]   s_tab[12] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101, 4'b0100, 4'b0101,
                                4'b0011, 4'b0011, 4'b0011, 4'b0100, 4'b0101, 4'b0011};
    logic [W-1:0] a_tab[12] = '{32'd100, 32'd100, 32'd9, 32'd9, 32'd5, 32'd5,
                                32'd0, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h8000_0001};
    logic [W-1:0] b_tab[12] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd9, 32'd9,
                                32'hDEADBEEF, 32'd0, 32'h9ABCDEF0, 32'd1, 32'h8000_0000,
                                32'h0000_0003};
    logic [2*W:0] e;
    logic [2*W:0] o;
    int n;
    for (int i = 0; i < 12; i++) send(s_tab[i], a_tab[i], b_tab[i], 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      s = 4'($urandom_range(3, 5));
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 300)) : $urandom;
      send(s, a, b, 1'b1);
    end
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL iter_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL iter_result got=%h exp=%h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL iter_extra got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_op_hold;
    logic [2*W:0] e;
    logic [2*W:0] o;
    int n;
    send(4'b0100, 32'd100, 32'd7, 1'b1);
    @(posedge clk);
    #1;
    // garbage offered while busy must be dropped
    i_op1 = $urandom;
    i_op2 = 32'd0;
    Sel = 4'b0101;
    i_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_op1 = 32'hFFFF_0000;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL hold_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL hold_result got=%h exp=%h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL hold_extra got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_abort;
    int pc;
    send(4'b0010, 32'd1, 32'd2, 1'b0);
    repeat (2) @(negedge clk);
    pc = pulse_cnt;
    send(4'b0011, 32'd3, 32'd4, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", o_valid); end
    checks++; if (r_out !== '0) begin failures++; $display("FAIL abort_out got=%h exp=0", r_out); end
    checks++; if (Zflag !== 1'b1) begin failures++; $display("FAIL abort_z got=%b exp=1", Zflag); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
    repeat (60) @(negedge clk);
    checks++; if (pulse_cnt !== pc) begin failures++; $display("FAIL abort_no_pulse got=%0d exp=%0d", pulse_cnt, pc); end
    obs_q.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    pulse_cnt = 0;
    prev_pulse_cyc = 0;
    last_pulse_cyc = 0;
    rst = 1'b1;
    i_valid = 1'b0;
    i_op1 = '0;
    i_op2 = '0;
    Sel = '0;
    test_reset();
    test_single_cycle();
    test_latency();
    test_back_to_back();
    test_mul_div();
    test_op_hold();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
